// File: rtl/wb_pbus_decoder_pkg.sv
// -----------------------------------------------------------------------------
// wb_pbus_decoder_pkg
// Shared types and defaults for the Wishbone peripheral-bus decoder.
//   PBUS_SLOT_AW / PBUS_NUM_SLOTS / PBUS_BASE : default slot geometry of the
//                                               0x2000_xxxx peripheral region
//   wb_master_t  : Wishbone B4 request  (cyc, stb, we, adr, dat, sel)
//   wb_slave_t   : Wishbone B4 response (dat, ack, err, rty, stall)
//   pbus_state_e : decoder FSM states
//   pbus_req_t   : request latched at accept, held for the whole access
// -----------------------------------------------------------------------------
package wb_pbus_decoder_pkg;

    localparam int          PBUS_SLOT_AW    = 12;
    localparam int          PBUS_NUM_SLOTS  = 8;
    localparam logic [31:0] PBUS_BASE       = 32'h2000_0000;
    // Slot index is always 4 bits: the region decodes up to 16 slots.
    localparam int          PBUS_SLOT_IDX_W = 4;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_master_t;

    typedef struct packed {
        logic [31:0] dat;
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
    } wb_slave_t;

    typedef enum logic [1:0] {
        PB_IDLE   = 2'd0,
        PB_ACCESS = 2'd1,
        PB_RESP   = 2'd2
    } pbus_state_e;

    typedef struct packed {
        logic [31:0]                adr;
        logic [31:0]                dat;
        logic [3:0]                 sel;
        logic                       we;
        logic [PBUS_SLOT_IDX_W-1:0] slot;
        logic                       hit;
    } pbus_req_t;

endpackage

// File: rtl/wb_pbus_decoder_addr_decode.sv
// -----------------------------------------------------------------------------
// wb_pbus_decoder_addr_decode
// Combinational address decoder for the peripheral region.
//   i_adr_hi : Wishbone address bits above the in-slot offset (adr[31:SLOT_AW])
//   o_slot   : 4-bit slot index (adr[SLOT_AW+3:SLOT_AW])
//   o_hit    : region matches, slot exists and slot is enabled
// -----------------------------------------------------------------------------
module wb_pbus_decoder_addr_decode
    import wb_pbus_decoder_pkg::*;
#(
    parameter int                   NUM_SLOTS = PBUS_NUM_SLOTS,
    parameter int                   SLOT_AW   = PBUS_SLOT_AW,
    parameter logic [31:0]          BASE_ADDR = PBUS_BASE,
    parameter logic [NUM_SLOTS-1:0] SLOT_EN   = '1
) (
    input  logic [31-SLOT_AW:0]         i_adr_hi,
    output logic [PBUS_SLOT_IDX_W-1:0]  o_slot,
    output logic                        o_hit
);

    // Width of the region tag above the slot index.
    localparam int          RW     = 32 - SLOT_AW - PBUS_SLOT_IDX_W;
    // Enable mask widened to all 16 slot codes; missing slots read as disabled.
    localparam logic [15:0] EN_EXT = 16'(SLOT_EN);

    logic w_region;
    logic w_in_range;

    always_comb begin
        o_slot     = i_adr_hi[PBUS_SLOT_IDX_W-1:0];
        w_region   = (i_adr_hi[31-SLOT_AW -: RW] == BASE_ADDR[31 -: RW]);
        w_in_range = ({1'b0, o_slot} < 5'(NUM_SLOTS));
        o_hit      = w_region && w_in_range && EN_EXT[o_slot];
    end

endmodule

// File: rtl/wb_pbus_decoder.sv
// -----------------------------------------------------------------------------
// wb_pbus_decoder
// Wishbone B4 pipelined slave for the peripheral region. Each request is
// decoded into one of NUM_SLOTS slots, registered, and forwarded to that slot
// as a single outstanding access guarded by a timeout. Misses, disabled slots,
// peripheral errors and timeouts all answer with err so the bus never hangs.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   wb_m_i/wb_s_o  : Wishbone request / response
//   pbus_addr_o    : registered offset within the slot
//   pbus_wdata_o   : registered write data
//   pbus_wstrb_o   : registered byte strobes (0 on reads)
//   pbus_we_o      : registered write enable
//   pbus_valid_o   : one-hot request to the addressed slot during an access
//   pbus_rdata_i   : per-slot read data
//   pbus_ready_i   : per-slot completion
//   pbus_err_i     : per-slot error, only looked at together with ready
//   timeout_o      : one-cycle pulse when an access times out
// -----------------------------------------------------------------------------
module wb_pbus_decoder
    import wb_pbus_decoder_pkg::*;
#(
    parameter int                   NUM_SLOTS   = PBUS_NUM_SLOTS,
    parameter int                   SLOT_AW     = PBUS_SLOT_AW,
    parameter logic [31:0]          BASE_ADDR   = PBUS_BASE,
    parameter logic [NUM_SLOTS-1:0] SLOT_EN     = '1,
    parameter int                   TIMEOUT_CYC = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  wb_master_t                  wb_m_i,
    output wb_slave_t                   wb_s_o,
    output logic [SLOT_AW-1:0]          pbus_addr_o,
    output logic [31:0]                 pbus_wdata_o,
    output logic [3:0]                  pbus_wstrb_o,
    output logic                        pbus_we_o,
    output logic [NUM_SLOTS-1:0]        pbus_valid_o,
    input  logic [NUM_SLOTS-1:0][31:0]  pbus_rdata_i,
    input  logic [NUM_SLOTS-1:0]        pbus_ready_i,
    input  logic [NUM_SLOTS-1:0]        pbus_err_i,
    output logic                        timeout_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    pbus_state_e                  r_state;
    pbus_state_e                  w_next_state;
    pbus_req_t                    r_req;
    logic [CNT_W-1:0]             r_cnt;
    logic [31:0]                  r_rdata;
    logic                         r_err;
    logic                         r_timeout;

    logic [PBUS_SLOT_IDX_W-1:0]   w_dec_slot;
    logic                         w_dec_hit;
    logic                         w_accept;
    logic                         w_sel_ready;
    logic                         w_cnt_last;
    logic [15:0][31:0]            w_rdata_ext;
    logic [15:0]                  w_ready_ext;
    logic [15:0]                  w_err_ext;
    logic                         w_unused_adr;

    wb_pbus_decoder_addr_decode #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_AW   (SLOT_AW),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_EN   (SLOT_EN)
    ) u_addr_decode (
        .i_adr_hi (wb_m_i.adr[31:SLOT_AW]),
        .o_slot   (w_dec_slot),
        .o_hit    (w_dec_hit)
    );

    // Per-slot inputs widened to 16 entries so the 4-bit slot index selects
    // without width games; entries past NUM_SLOTS are never selected on a hit.
    always_comb begin
        w_rdata_ext = '0;
        w_ready_ext = '0;
        w_err_ext   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_rdata_ext[i] = pbus_rdata_i[i];
            w_ready_ext[i] = pbus_ready_i[i];
            w_err_ext[i]   = pbus_err_i[i];
        end
    end

    assign w_accept    = wb_m_i.cyc && wb_m_i.stb;
    assign w_sel_ready = w_ready_ext[r_req.slot];
    assign w_cnt_last  = (r_cnt == CNT_LAST);

    // Only the in-slot offset of the latched address leaves the block.
    assign w_unused_adr = ^r_req.adr[31:SLOT_AW];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= PB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. Losing cyc aborts from any busy state; ready is
    // checked before the timeout so a last-cycle completion is still normal.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PB_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_dec_hit ? PB_ACCESS : PB_RESP;
                end
            end
            PB_ACCESS: begin
                if (!wb_m_i.cyc) begin
                    w_next_state = PB_IDLE;
                end else if (w_sel_ready || w_cnt_last) begin
                    w_next_state = PB_RESP;
                end
            end
            PB_RESP: begin
                w_next_state = PB_IDLE;
            end
            default: begin
                w_next_state = PB_IDLE;
            end
        endcase
    end

    // Request latch, response capture and timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req     <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                PB_IDLE: begin
                    if (w_accept) begin
                        r_req.adr  <= wb_m_i.adr;
                        r_req.dat  <= wb_m_i.dat;
                        r_req.sel  <= wb_m_i.sel;
                        r_req.we   <= wb_m_i.we;
                        r_req.slot <= w_dec_slot;
                        r_req.hit  <= w_dec_hit;
                        r_err      <= !w_dec_hit;
                        r_rdata    <= '0;
                    end
                end
                PB_ACCESS: begin
                    if (wb_m_i.cyc) begin
                        if (w_sel_ready) begin
                            r_rdata <= w_rdata_ext[r_req.slot];
                            r_err   <= w_err_ext[r_req.slot];
                        end else if (w_cnt_last) begin
                            r_err     <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
            // Counts only while staying in ACCESS, so every new access and
            // every abort starts from zero.
            if ((r_state == PB_ACCESS) && (w_next_state == PB_ACCESS)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Output logic. The response is gated by cyc so an abort during RESP
    // emits neither ack nor err.
    always_comb begin
        wb_s_o       = '0;
        pbus_valid_o = '0;
        case (r_state)
            PB_IDLE: begin
                wb_s_o.stall = 1'b0;
            end
            PB_ACCESS: begin
                wb_s_o.stall = 1'b1;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    pbus_valid_o[i] = r_req.hit && (r_req.slot == PBUS_SLOT_IDX_W'(i));
                end
            end
            PB_RESP: begin
                wb_s_o.stall = 1'b1;
                if (wb_m_i.cyc) begin
                    wb_s_o.ack = !r_err;
                    wb_s_o.err = r_err;
                    if (!r_err && !r_req.we) begin
                        wb_s_o.dat = r_rdata;
                    end
                end
            end
            default: begin
                wb_s_o.stall = 1'b0;
            end
        endcase
        wb_s_o.rty = 1'b0;
    end

    assign pbus_addr_o  = r_req.adr[SLOT_AW-1:0];
    assign pbus_wdata_o = r_req.dat;
    assign pbus_wstrb_o = r_req.we ? r_req.sel : 4'b0000;
    assign pbus_we_o    = r_req.we;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_wb_pbus_decoder.sv
// -----------------------------------------------------------------------------
// tb_wb_pbus_decoder
// Drives directed and random Wishbone transactions and compares every cycle
// of the response against a transaction-level model of the decoder.
// -----------------------------------------------------------------------------
module tb_wb_pbus_decoder;
    import wb_pbus_decoder_pkg::*;

    localparam int          NS   = 8;
    localparam int          AW   = 12;
    localparam int          TO   = 8;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [7:0]  EN   = 8'h7F;

    logic                 clk = 1'b0;
    logic                 rst;
    wb_master_t           wb_m;
    wb_slave_t            wb_s;
    logic [AW-1:0]        p_addr;
    logic [31:0]          p_wdata;
    logic [3:0]           p_wstrb;
    logic                 p_we;
    logic [NS-1:0]        p_valid;
    logic [NS-1:0][31:0]  p_rdata;
    logic [NS-1:0]        p_ready;
    logic [NS-1:0]        p_err;
    logic                 tmo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_pbus_decoder #(
        .NUM_SLOTS   (NS),
        .SLOT_AW     (AW),
        .BASE_ADDR   (BASE),
        .SLOT_EN     (EN),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wb_m_i       (wb_m),
        .wb_s_o       (wb_s),
        .pbus_addr_o  (p_addr),
        .pbus_wdata_o (p_wdata),
        .pbus_wstrb_o (p_wstrb),
        .pbus_we_o    (p_we),
        .pbus_valid_o (p_valid),
        .pbus_rdata_i (p_rdata),
        .pbus_ready_i (p_ready),
        .pbus_err_i   (p_err),
        .timeout_o    (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Region is 16 slots of 4 KiB starting at BASE.
    function automatic bit model_hit(input logic [31:0] a);
        int slot;
        if (a < BASE || a >= BASE + 32'h0001_0000) return 1'b0;
        slot = int'((a - BASE) / 4096);
        if (slot >= NS) return 1'b0;
        return EN[slot];
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_stall"}, 32'(wb_s.stall), 32'd0);
        chk({tag, "_ack"},   32'(wb_s.ack),   32'd0);
        chk({tag, "_err"},   32'(wb_s.err),   32'd0);
        chk({tag, "_valid"}, 32'(p_valid),    32'd0);
        chk({tag, "_tmo"},   32'(tmo),        32'd0);
    endtask

    // One complete transaction; k = wait cycles before the peripheral is ready.
    task automatic xfer(input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input logic [3:0] sel, input int k, input bit perr,
                        input logic [31:0] rd);
        bit          hit;
        int          slot, n_acc, j, o;
        bit          ack_e, err_e, tmo_e;
        logic [31:0] dat_e, valid_e;
        hit  = model_hit(a);
        slot = hit ? int'((a - BASE) / 4096) : 0;
        if (!hit) begin
            n_acc = 0;  ack_e = 1'b0;  err_e = 1'b1;  tmo_e = 1'b0;
        end else if (k < TO) begin
            n_acc = k + 1;  ack_e = !perr;  err_e = perr;  tmo_e = 1'b0;
        end else begin
            n_acc = TO;  ack_e = 1'b0;  err_e = 1'b1;  tmo_e = 1'b1;
        end
        dat_e   = (ack_e && !we) ? rd : 32'd0;
        valid_e = 32'd1 << slot;

        @(negedge clk);
        chk("accept_stall", 32'(wb_s.stall), 32'd0);
        chk("accept_valid", 32'(p_valid), 32'd0);
        wb_m    = '{cyc: 1'b1, stb: 1'b1, we: we, adr: a, dat: wd, sel: sel};
        p_ready = '0;
        p_err   = '0;
        for (int i = 0; i < NS; i++) p_rdata[i] = $urandom;
        if (hit) p_rdata[slot] = rd;

        for (int c = 1; c <= n_acc + 2; c++) begin
            @(negedge clk);
            if (c <= n_acc) begin
                chk("acc_valid", 32'(p_valid),    valid_e);
                chk("acc_stall", 32'(wb_s.stall), 32'd1);
                chk("acc_ack",   32'(wb_s.ack),   32'd0);
                chk("acc_err",   32'(wb_s.err),   32'd0);
                chk("acc_tmo",   32'(tmo),        32'd0);
                if (c == 1) begin
                    chk("acc_addr",  32'(p_addr),  (a - BASE) % 4096);
                    chk("acc_wstrb", 32'(p_wstrb), we ? 32'(sel) : 32'd0);
                    chk("acc_we",    32'(p_we),    32'(we));
                    chk("acc_wdata", p_wdata,      wd);
                end
            end else if (c == n_acc + 1) begin
                chk("resp_ack",   32'(wb_s.ack),   32'(ack_e));
                chk("resp_err",   32'(wb_s.err),   32'(err_e));
                chk("resp_dat",   wb_s.dat,        dat_e);
                chk("resp_stall", 32'(wb_s.stall), 32'd1);
                chk("resp_valid", 32'(p_valid),    32'd0);
                chk("resp_tmo",   32'(tmo),        32'(tmo_e));
            end else begin
                check_idle("post");
            end
            // Inputs for the current cycle
            wb_m.stb = 1'b0;
            p_ready  = '0;
            p_err    = '0;
            if (c <= n_acc) begin
                j = c - 1;
                if (k < TO && j >= k) begin
                    p_ready[slot] = 1'b1;
                    p_err[slot]   = perr;
                end else begin
                    o = (slot + 1 + int'($urandom_range(0, NS - 2))) % NS;
                    p_ready[o] = 1'b1;
                    p_err[o]   = 1'($urandom);
                end
            end
            if (c == n_acc + 1) wb_m.cyc = 1'b0;
        end
    endtask

    // Start an access to a hit slot, then drop cyc or assert reset in ACCESS
    // cycle j_ab+1 (j_ab <= TO-2 keeps it clear of the timeout).
    task automatic abort_xfer(input logic [31:0] a, input int j_ab, input bit use_rst);
        int          slot;
        logic [31:0] valid_e;
        slot    = int'((a - BASE) / 4096);
        valid_e = 32'd1 << slot;
        @(negedge clk);
        wb_m    = '{cyc: 1'b1, stb: 1'b1, we: 1'b1, adr: a, dat: $urandom, sel: 4'hF};
        p_ready = '0;
        p_err   = '0;
        for (int c = 1; c <= j_ab + 1; c++) begin
            @(negedge clk);
            chk("abt_valid", 32'(p_valid), valid_e);
            wb_m.stb = 1'b0;
            if (c == j_ab + 1) begin
                if (use_rst) rst = 1'b1;
                else         wb_m.cyc = 1'b0;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle(use_rst ? "rst_abt" : "cyc_abt");
            if (use_rst && c == 0) begin
                chk("rst_abt_addr",  32'(p_addr),  32'd0);
                chk("rst_abt_wdata", p_wdata,      32'd0);
                chk("rst_abt_wstrb", 32'(p_wstrb), 32'd0);
                chk("rst_abt_we",    32'(p_we),    32'd0);
            end
            rst      = 1'b0;
            wb_m.cyc = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        rst     = 1'b1;
        wb_m    = '0;
        p_ready = '0;
        p_err   = '0;
        p_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_dat",   wb_s.dat,        32'd0);
        chk("reset_rty",   32'(wb_s.rty),   32'd0);
        chk("reset_addr",  32'(p_addr),     32'd0);
        chk("reset_wdata", p_wdata,         32'd0);
        chk("reset_wstrb", 32'(p_wstrb),    32'd0);
        chk("reset_we",    32'(p_we),       32'd0);
        rst = 1'b0;

        xfer(32'h2000_0010, 1'b0, 32'd0,         4'hF,    0, 1'b0, 32'hDEAD_BEEF);
        xfer(32'h2000_2004, 1'b1, 32'h1234_5678, 4'b0011, 0, 1'b0, 32'h0BAD_F00D);
        xfer(32'h2000_2008, 1'b0, 32'd0,         4'b0011, 1, 1'b0, 32'hA5A5_0001);
        xfer(32'h2000_7000, 1'b0, 32'd0,         4'hF,    0, 1'b0, 32'h1111_1111);
        xfer(32'h2100_0000, 1'b1, 32'h5555_AAAA, 4'hF,    0, 1'b0, 32'h2222_2222);
        xfer(32'h2000_9000, 1'b0, 32'd0,         4'hF,    0, 1'b0, 32'h3333_3333);
        xfer(32'h2000_3000, 1'b0, 32'd0,         4'hF,  100, 1'b0, 32'h4444_4444);
        xfer(32'h2000_3004, 1'b0, 32'd0,         4'hF,    0, 1'b0, 32'h5151_5151);
        xfer(32'h2000_3008, 1'b0, 32'd0,         4'hF, TO-1, 1'b0, 32'h6666_6666);
        xfer(32'h2000_400C, 1'b0, 32'd0,         4'hF,    3, 1'b1, 32'h7777_7777);
        abort_xfer(32'h2000_5010, 2, 1'b0);
        xfer(32'h2000_5014, 1'b0, 32'd0,         4'hF,    1, 1'b0, 32'h8888_8888);
        abort_xfer(32'h2000_6020, 1, 1'b1);
        xfer(32'h2000_6024, 1'b1, 32'hCAFE_0001, 4'b1100, 2, 1'b0, 32'h9999_9999);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 8)
                a = BASE + 32'($urandom_range(0, 15)) * 32'd4096 + ($urandom & 32'h0000_0FFC);
            else
                a = $urandom;
            xfer(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 11)),
                 ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
